// File: rtl/tlul_pkg.sv
// TL-UL channel structs: host-to-device (A + d_ready) and device-to-host (D + a_ready).
// Latency: n/a (types only).
// Backpressure: a_ready / d_ready carried inside the opposite-direction struct.
package tlul_pkg;

    import top_pkg::*;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic [TL_AUW-1:0]   a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [TL_DUW-1:0]   d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_rob_pkg.sv
// Re-order buffer entry types and the D-source range check.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package tlul_rob_pkg;

    import top_pkg::*;

    typedef enum logic [1:0] {
        Free    = 2'h0,
        Pending = 2'h1,
        Ready   = 2'h2
    } rob_state_e;

    // One slot: lifecycle state, the host's original source id, and the
    // response fields that get replayed to the host once the slot is oldest.
    typedef struct packed {
        rob_state_e          state;
        logic [TL_AIW-1:0]   host_src;
        logic [2:0]          d_opcode;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
    } rob_entry_t;

    // True when a device D source can name a ROB slot at all.
    function automatic logic rob_src_ok(input logic [TL_AIW-1:0] d_source,
                                        input int unsigned depth);
        return 32'(d_source) < depth;
    endfunction

endpackage

// File: rtl/top_pkg.sv
// Fabric-wide TL-UL bus dimensions shared by every TL-UL block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package top_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 16;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

endpackage

// File: rtl/tlul_rob_v2_ctr.sv
// Occupancy up/down counter with full/empty flags for the re-order buffer.
// Latency: count, full and empty are registered; they reflect inc/dec one cycle later.
// Backpressure: none; the caller must never inc when full nor dec when empty.
// Ports: clk_i/rst_ni clock and async active-low reset; inc/dec one-cycle
//        strobes; count current occupancy; full/empty decoded flags.
module tlul_rob_v2_ctr #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc && !dec) begin
            count_q <= count_q + 1'b1;
        end else if (dec && !inc) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/tlul_rob_v2.sv
// TL-UL re-order buffer: device may answer out of order, host sees responses in request order.
// Latency: A channel combinational; D bypasses in zero cycles when the beat is for the oldest slot, else stored.
// Backpressure: host a_ready drops when all slots are in use; host d_ready stalls draining; device D never stalled.
// Ports: clk_i/rst_ni clock and async active-low reset; host_i/host_o host-side
//        TL-UL; device_o/device_i device-side TL-UL (A source remapped to slot
//        index); occupancy_o live slots; idle_o no live slots; err_spurious_o
//        one-cycle pulse after a dropped D beat.
module tlul_rob_v2
    import top_pkg::*;
    import tlul_pkg::*;
    import tlul_rob_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  tl_h2d_t        host_i,
    output tl_d2h_t        host_o,
    output tl_h2d_t        device_o,
    input  tl_d2h_t        device_i,
    output logic [IDX_W:0] occupancy_o,
    output logic           idle_o,
    output logic           err_spurious_o
);

    rob_entry_t       entries_q [DEPTH];
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic             spur_q;

    logic             full;
    logic             empty;
    logic             accept;
    logic             beat_ok;
    logic             tail_rdy;
    logic             bypass;
    logic             d_vld;
    logic             pop;
    logic [IDX_W-1:0] d_idx;

    // full is a registered flag, so host a_ready never depends on this
    // cycle's device D beat or host d_ready.
    assign accept = host_i.a_valid && device_i.a_ready && !full;

    // Only the low bits index the array; rob_src_ok rejects anything wider.
    assign d_idx    = device_i.d_source[IDX_W-1:0];
    assign beat_ok  = device_i.d_valid
                   && rob_src_ok(device_i.d_source, DEPTH)
                   && (entries_q[d_idx].state == Pending);
    assign tail_rdy = (entries_q[tail_q].state == Ready);
    // A beat for the oldest slot goes straight through unless an earlier
    // stored response for that slot is already being shown (cannot happen,
    // since a Ready slot rejects beats, but keeps the mux priority explicit).
    assign bypass   = beat_ok && !tail_rdy && (d_idx == tail_q);
    assign d_vld    = tail_rdy || bypass;
    assign pop      = d_vld && host_i.d_ready;

    always_comb begin
        device_o          = host_i;
        device_o.a_valid  = host_i.a_valid && !full;
        device_o.a_source = TL_AIW'(head_q);
        device_o.a_user   = '0;
        device_o.d_ready  = 1'b1;
    end

    always_comb begin
        host_o          = '0;
        host_o.a_ready  = device_i.a_ready && !full;
        host_o.d_valid  = d_vld;
        host_o.d_source = entries_q[tail_q].host_src;
        if (tail_rdy) begin
            host_o.d_opcode = entries_q[tail_q].d_opcode;
            host_o.d_size   = entries_q[tail_q].d_size;
            host_o.d_data   = entries_q[tail_q].d_data;
            host_o.d_error  = entries_q[tail_q].d_error;
        end else if (bypass) begin
            host_o.d_opcode = device_i.d_opcode;
            host_o.d_size   = device_i.d_size;
            host_o.d_data   = device_i.d_data;
            host_o.d_error  = device_i.d_error;
        end
    end

    // Accept, store and pop always land on different slots in one cycle:
    // the head slot is Free, the stored beat's slot is Pending, and a pop
    // either frees a Ready tail or the bypassed Pending tail (which then
    // skips the store).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            spur_q <= 1'b0;
        end else begin
            if (accept) begin
                entries_q[head_q] <= '{state: Pending, host_src: host_i.a_source, default: '0};
                head_q            <= head_q + 1'b1;
            end
            if (beat_ok && !(bypass && host_i.d_ready)) begin
                entries_q[d_idx].state    <= Ready;
                entries_q[d_idx].d_opcode <= device_i.d_opcode;
                entries_q[d_idx].d_size   <= device_i.d_size;
                entries_q[d_idx].d_data   <= device_i.d_data;
                entries_q[d_idx].d_error  <= device_i.d_error;
            end
            if (pop) begin
                entries_q[tail_q].state <= Free;
                tail_q                  <= tail_q + 1'b1;
            end
            spur_q <= device_i.d_valid && !beat_ok;
        end
    end

    tlul_rob_v2_ctr #(
        .DEPTH (DEPTH)
    ) u_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (accept),
        .dec    (pop),
        .count  (occupancy_o),
        .full   (full),
        .empty  (empty)
    );

    assign idle_o         = empty;
    assign err_spurious_o = spur_q;

    // Device D fields that have no place in the stored entry.
    logic unused_dev;
    assign unused_dev = ^{device_i.d_param, device_i.d_sink, device_i.d_user};

endmodule

// File: tb/tb_tlul_rob_v2.sv
// Bench for tlul_rob_v2: directed scenarios then random traffic against an in-order reference.
// Latency: n/a.
// Backpressure: bench randomises host d_ready and device a_ready.
module tb_tlul_rob_v2;

    import top_pkg::*;
    import tlul_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    tl_h2d_t    h2d;
    tl_d2h_t    d2h;
    tl_h2d_t    dev_o;
    tl_d2h_t    dev_i;
    logic [2:0] occ;
    logic       idle;
    logic       err;

    always #5 clk = ~clk;

    tlul_rob_v2 #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .host_i         (h2d),
        .host_o         (d2h),
        .device_o       (dev_o),
        .device_i       (dev_i),
        .occupancy_o    (occ),
        .idle_o         (idle),
        .err_spurious_o (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference: host requests in arrival order, each tagged with the slot the
    // device was told to answer to; responses are remembered per slot until
    // the host consumes them in order.
    typedef struct {
        logic [7:0] src;
        int         slot;
    } req_t;

    req_t        ord_q[$];
    int          acc_cnt;
    bit          outst    [DEPTH];
    bit          answered [DEPTH];
    logic [31:0] rdata    [DEPTH];
    bit          exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        ord_q.delete();
        acc_cnt = 0;
        exp_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            outst[i]    = 1'b0;
            answered[i] = 1'b0;
            rdata[i]    = '0;
        end
    endtask

    task automatic idle_in();
        h2d           = '0;
        h2d.d_ready   = 1'b1;
        h2d.a_opcode  = Get;
        h2d.a_mask    = '1;
        dev_i         = '0;
        dev_i.a_ready = 1'b1;
    endtask

    task automatic host_req(input logic [7:0] src);
        h2d.a_valid   = 1'b1;
        h2d.a_source  = src;
        h2d.a_address = $urandom;
    endtask

    task automatic dev_beat(input int slot, input logic [31:0] data);
        dev_i.d_valid  = 1'b1;
        dev_i.d_source = 8'(slot);
        dev_i.d_opcode = AccessAckData;
        dev_i.d_data   = data;
    endtask

    // Check every output for the cycle now set up, then clock it and advance
    // the reference to match.
    task automatic tick();
        int          n;
        int          s;
        int          fs;
        bit          full;
        bit          exp_ardy;
        bit          acc;
        bit          good;
        bit          fans;
        bit          pop;
        bit          nerr;
        logic [31:0] fdata;
        logic [31:0] bdata;
        logic [7:0]  asrc;
        #1;
        n        = ord_q.size();
        full     = (n == DEPTH);
        exp_ardy = dev_i.a_ready && !full;
        chk("a_ready", d2h.a_ready, exp_ardy);
        chk("dev_a_valid", dev_o.a_valid, h2d.a_valid && !full);
        chk("dev_d_ready", dev_o.d_ready, 1'b1);
        acc  = h2d.a_valid && exp_ardy;
        asrc = h2d.a_source;
        if (acc) chk("dev_a_source", dev_o.a_source, acc_cnt % DEPTH);
        s     = dev_i.d_source;
        bdata = dev_i.d_data;
        good  = dev_i.d_valid && (s < DEPTH) && outst[s % DEPTH] && !answered[s % DEPTH];
        fans  = 1'b0;
        fdata = '0;
        fs    = 0;
        if (n > 0) begin
            fs = ord_q[0].slot;
            if (answered[fs]) begin
                fans  = 1'b1;
                fdata = rdata[fs];
            end else if (good && s == fs) begin
                fans  = 1'b1;
                fdata = bdata;
            end
        end
        chk("d_valid", d2h.d_valid, fans);
        if (fans) begin
            chk("d_source", d2h.d_source, ord_q[0].src);
            chk("d_data", d2h.d_data, fdata);
        end
        chk("err_spurious", err, exp_err);
        chk("occupancy", occ, n);
        chk("idle", idle, n == 0);
        pop  = fans && h2d.d_ready;
        nerr = dev_i.d_valid && !good;
        @(posedge clk);
        #1;
        if (good) begin
            answered[s] = 1'b1;
            rdata[s]    = bdata;
        end
        if (pop) begin
            outst[fs]    = 1'b0;
            answered[fs] = 1'b0;
            void'(ord_q.pop_front());
        end
        if (acc) begin
            ord_q.push_back('{src: asrc, slot: acc_cnt % DEPTH});
            outst[acc_cnt % DEPTH] = 1'b1;
            acc_cnt++;
        end
        exp_err = nerr;
    endtask

    initial begin
        int          slot;
        int          cand[$];
        int          budget;
        logic [31:0] pat;

        idle_in();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", occ, 0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_d_valid", d2h.d_valid, 1'b0);
        rst_n = 1'b1;

        // In-order answers with host ready: every beat passes straight through.
        for (int i = 0; i < 4; i++) begin
            host_req(8'h11 + 8'(i));
            tick();
        end
        idle_in();
        for (int i = 0; i < 4; i++) begin
            dev_beat(i, 32'hA0 + 32'(i));
            #1;
            chk("t1_bypass_valid", d2h.d_valid, 1'b1);
            chk("t1_bypass_src", d2h.d_source, 8'h11 + 8'(i));
            tick();
        end
        idle_in();
        tick();
        chk("t1_occ_end", occ, 0);

        // Answers in order 3,1,2,0: host sees D0..D3 on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            host_req(8'h21 + 8'(i));
            tick();
        end
        idle_in();
        dev_beat(3, 32'hD3); #1; chk("t2_hold3", d2h.d_valid, 1'b0); tick();
        dev_beat(1, 32'hD1); #1; chk("t2_hold1", d2h.d_valid, 1'b0); tick();
        dev_beat(2, 32'hD2); #1; chk("t2_hold2", d2h.d_valid, 1'b0); tick();
        dev_beat(0, 32'hD0); #1; chk("t2_d0", d2h.d_data, 32'hD0); tick();
        idle_in();
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("t2_valid", d2h.d_valid, 1'b1);
            chk("t2_data", d2h.d_data, 32'hD0 + 32'(i));
            tick();
        end
        chk("t2_occ_end", occ, 0);

        // Five back-to-back requests: the fifth waits for a free slot.
        for (int i = 0; i < 5; i++) begin
            host_req(8'h31 + 8'(i));
            tick();
        end
        #1;
        chk("t3_full_ardy", d2h.a_ready, 1'b0);
        chk("t3_full_occ", occ, 4);
        dev_beat(0, 32'h300);
        tick();
        dev_i.d_valid = 1'b0;
        #1;
        chk("t3_fifth_ardy", d2h.a_ready, 1'b1);
        chk("t3_fifth_src", dev_o.a_source, 0);
        tick();
        idle_in();
        for (int i = 1; i < 5; i++) begin
            dev_beat(i % DEPTH, 32'h300 + 32'(i));
            tick();
        end
        idle_in();
        tick();
        chk("t3_occ_end", occ, 0);

        // Host stalls while the oldest response arrives: it must be held, not lost.
        slot = acc_cnt % DEPTH;
        host_req(8'h41);
        tick();
        idle_in();
        h2d.d_ready = 1'b0;
        dev_beat(slot, 32'hCAFE);
        tick();
        dev_i.d_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_held_valid", d2h.d_valid, 1'b1);
            chk("t4_held_data", d2h.d_data, 32'hCAFE);
            tick();
        end
        h2d.d_ready = 1'b1;
        tick();
        #1;
        chk("t4_drained", d2h.d_valid, 1'b0);
        chk("t4_occ_end", occ, 0);

        // Beats for a Free slot and for an out-of-range source are dropped.
        dev_beat(2, 32'h55);
        tick();
        idle_in();
        #1;
        chk("t5_err_pulse", err, 1'b1);
        chk("t5_occ", occ, 0);
        tick();
        #1;
        chk("t5_err_clear", err, 1'b0);
        dev_beat(9, 32'h66);
        tick();
        idle_in();
        tick();

        // Reset mid-operation drops everything; late answers become spurious.
        slot = acc_cnt % DEPTH;
        host_req(8'h61); tick();
        host_req(8'h62); tick();
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_idle", idle, 1'b1);
        chk("t6_rst_dvalid", d2h.d_valid, 1'b0);
        chk("t6_rst_occ", occ, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dev_beat(slot, 32'h77);
        tick();
        dev_beat((slot + 1) % DEPTH, 32'h78);
        tick();
        idle_in();
        #1;
        chk("t6_late_err", err, 1'b1);
        tick();

        // Random traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            idle_in();
            if ($urandom_range(0, 1) == 1) host_req(8'($urandom));
            dev_i.a_ready = ($urandom_range(0, 3) != 0);
            h2d.d_ready   = ($urandom_range(0, 3) != 0);
            cand.delete();
            for (int k = 0; k < DEPTH; k++) begin
                if (outst[k] && !answered[k]) cand.push_back(k);
            end
            pat = $urandom;
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                dev_beat(cand[$urandom_range(0, cand.size() - 1)], pat);
                dev_i.d_error = pat[0] & pat[1];
                dev_i.d_size  = pat[5:4];
            end else if ($urandom_range(0, 15) == 0) begin
                dev_beat($urandom_range(0, 15), pat);
            end
            tick();
        end

        // Drain whatever is left, bounded.
        idle_in();
        budget = 0;
        while (ord_q.size() > 0 && budget < 100) begin
            idle_in();
            for (int k = 0; k < DEPTH; k++) begin
                if (outst[k] && !answered[k] && !dev_i.d_valid) dev_beat(k, $urandom);
            end
            tick();
            budget++;
        end
        idle_in();
        tick();
        #1;
        chk("drain_occ", occ, 0);
        chk("drain_idle", idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlul_rob_v2.md
Name: tlul_rob_v2

Overview:
Parametrised TL-UL re-order buffer between one TL-UL host and one TL-UL device fabric that may answer out of order. Guarantees that host D responses are returned in host A-request order. Improvements over the first generation:
- Honours host d_ready backpressure.
- Never back-pressures the device D channel.
- Detects and drops spurious responses.
- Reports occupancy and idle.

Parameters:
DEPTH, 4, number of ROB entries and maximum outstanding requests; power of two, 2..2**TL_AIW.
IDX_W, $clog2(DEPTH), derived localparam; entry index width, zero-extended onto a_source.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
host_i  in  tl_h2d_t  host A request, host d_ready
host_o  out  tl_d2h_t  ordered D response, a_ready
device_o  out  tl_h2d_t  A request with remapped source, d_ready
device_i  in  tl_d2h_t  device D response (any order), a_ready
occupancy_o  out  IDX_W+1  number of non-Free entries
idle_o  out  1  occupancy_o == 0
err_spurious_o  out  1  one-cycle pulse: dropped D beat with invalid source

Behaviour:
- Entry state per slot: Free, Pending (request issued, no response), Ready (response stored, awaiting host).
- Stored fields per entry:
  - host a_source
  - d_opcode, d_size, d_data, d_error
- head: next slot to allocate. tail: oldest non-Free slot. Both IDX_W wide and wrap modulo DEPTH.
- Reset values:
  - All entries Free with zeroed fields; head = tail = 0.
  - Outputs: occupancy_o 0, idle_o 1, err_spurious_o 0, host_o.d_valid 0.
- Full: occupancy_o == DEPTH.
- A channel is combinational pass-through:
  - device_o.a_valid = host_i.a_valid && !full.
  - device_o.a_source = zero-extended head.
  - a_user = 0; other A fields copied.
  - host_o.a_ready = device_i.a_ready && !full.
- A handshake (host_i.a_valid && host_o.a_ready):
  - entries[head] <= Pending, host_src <= host_i.a_source.
  - head++.
  - No combinational path from device D to host a_ready.
- device_o.d_ready is tied 1. Every Pending entry has reserved storage, so a response can always be absorbed.
- D beat classification (device_i.d_valid):
  - Valid when d_source < DEPTH and entries[d_source] is Pending; otherwise spurious.
  - Spurious beats are dropped, err_spurious_o pulses next cycle, state is unchanged.
- Host D output priority:
  1. entries[tail] Ready: drive the stored fields.
  2. Else a valid D beat with d_source == tail (bypass): drive the device fields combinationally.
  3. Else d_valid = 0.
  - d_source is always entries[tail].host_src.
- Pop: host_o.d_valid && host_i.d_ready sets entries[tail] to Free and tail++.
- Bypass beat with host_i.d_ready low: stored into entries[tail] as Ready (not lost); presented next cycle.
- Non-tail valid beat: stored into entries[d_source] as Ready.
- At most one pop per cycle. Drain rate is one response per cycle.
- Simultaneous events in one cycle:
  - Accept, valid D beat and pop may all occur together. They touch distinct entries (head slot is Free unless full; full blocks accept).
  - occupancy_o is updated as occupancy + accept - pop.
- Tail Ready while a device beat arrives for another Pending entry: the stored tail is presented, and the beat is written to its own entry.
- Wrap-around: head/tail overflow IDX_W naturally. With head == tail, occupancy_o distinguishes full from empty.
- Reset mid-operation: all state is discarded immediately. Responses still in flight afterwards are flagged spurious (target entry is Free) and dropped.
- The block must not be combinationally transparent from host d_ready to device d_ready.

Decomposition:
- New package tlul_rob_pkg:
  - rob_state_e {Free = 2'h0, Pending = 2'h1, Ready = 2'h2}
  - rob_entry_t packed struct
  - function rob_src_ok(d_source, depth)
- Types come from tlul_pkg/top_pkg.
- Storage, pointers and output mux stay in tlul_rob_v2. One sub-module is natural: tlul_rob_v2_ctr (occupancy up/down counter with full/empty flags).

Test Plan:
- DEPTH = 4; four reads with sources 0x11..0x14; device answers in order with host d_ready = 1 -> bypass every beat, host sees 0x11..0x14 on the same cycle as each device beat, occupancy returns to 0.
- Four requests; device answers in order 3,1,2,0 with data 0xD3,0xD1,0xD2,0xD0 -> host receives 0xD0,0xD1,0xD2,0xD3 on four consecutive cycles after the source-0 beat.
- Five host requests back-to-back, device a_ready = 1, no responses -> fifth held with a_ready = 0, occupancy_o = 4; one response to tail -> fifth accepted next cycle with device a_source = 0.
- Host d_ready = 0 while in-order beat for tail arrives (data 0xCAFE) -> beat stored; d_valid held with 0xCAFE until d_ready = 1; no beat lost.
- Device D beat with d_source = 2 while entry 2 is Free -> dropped, err_spurious_o = 1 for one cycle, occupancy unchanged.
- Two requests outstanding, rst_ni pulsed low mid-operation -> idle_o = 1 and host_o.d_valid = 0 immediately; late device responses flagged spurious.
